// File: rtl/tank_cmd_if.sv
// Bus between the keyboard/tick sources, the tank command scheduler and the game logic.
// Handshake: a command transfers on a rising clk edge where cmd_valid=1 and cmd_ready=1;
// while cmd_valid=1 and cmd_ready=0 the command fields hold stable; cmd_valid never depends on cmd_ready.
interface tank_cmd_if;
    logic       key_valid;
    logic [9:0] key_code;
    logic       tick;
    logic       cmd_ready;
    logic       cmd_valid;
    logic       cmd_player;
    logic [2:0] cmd_op;
    logic       busy;
    logic       overrun;
    logic [9:0] key_state;

    modport master (
        output key_valid, key_code, tick, cmd_ready,
        input  cmd_valid, cmd_player, cmd_op, busy, overrun, key_state
    );

    modport slave (
        input  key_valid, key_code, tick, cmd_ready,
        output cmd_valid, cmd_player, cmd_op, busy, overrun, key_state
    );
endinterface

// File: rtl/tank_cmd_scheduler.sv
// Turns PS/2 key events into per-tick tank commands (fire, then one move, per player),
// alternating which player is served first on each accepted game tick.
module tank_cmd_scheduler #(
    parameter int COOLDOWN = 8
) (
    input logic        clk,
    input logic        rst,
    tank_cmd_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, S0_FIRE, S0_MOVE, S1_FIRE, S1_MOVE} state_t;

    state_t          state, state_nx;
    logic [9:0]      key_state;
    logic [1:0]      fire_pend;
    logic [1:0][3:0] cooldown;
    logic            rr, seq_rr;
    logic [7:0]      snap_dirs;
    logic [3:0]      snap_work;
    logic            overrun_q;

    logic            key_hit, key_brk;
    logic [3:0]      key_idx;
    logic [1:0]      fire_make, fire_hs, cd_ready;
    logic [3:0]      live_work;
    logic            hs, cur_player, cur_fire;
    logic [2:0]      cur_op;
    logic [3:0]      cur_dirs;

    function automatic logic [3:0] dirs_of(input logic [7:0] d, input logic p);
        return p ? d[7:4] : d[3:0];
    endfunction

    // Work bits in visiting order: {S1_MOVE, S1_FIRE, S0_MOVE, S0_FIRE}.
    function automatic logic [3:0] work_of(input logic [7:0] d, input logic [1:0] fp,
                                           input logic [1:0] cdr, input logic r);
        return {|dirs_of(d, ~r), fp[~r] & cdr[~r], |dirs_of(d, r), fp[r] & cdr[r]};
    endfunction

    function automatic state_t pick(input logic [3:0] w, input int start);
        state_t s;
        s = IDLE;
        for (int j = 3; j >= 0; j--)
            if (j >= start && w[j]) s = state_t'(3'(j + 1));
        return s;
    endfunction

    always_comb begin
        key_hit = 1'b0;
        key_idx = 4'd0;
        if (bus.key_valid && !bus.key_code[9]) begin
            key_hit = 1'b1;
            case (bus.key_code[7:0])
                8'h1D:   key_idx = 4'd0;
                8'h1B:   key_idx = 4'd1;
                8'h1C:   key_idx = 4'd2;
                8'h23:   key_idx = 4'd3;
                8'h29:   key_idx = 4'd4;
                8'h43:   key_idx = 4'd5;
                8'h42:   key_idx = 4'd6;
                8'h3B:   key_idx = 4'd7;
                8'h4B:   key_idx = 4'd8;
                8'h5A:   key_idx = 4'd9;
                default: key_hit = 1'b0;
            endcase
        end
    end

    assign key_brk      = bus.key_code[8];
    assign fire_make[0] = key_hit && !key_brk && (key_idx == 4'd4);
    assign fire_make[1] = key_hit && !key_brk && (key_idx == 4'd9);

    // A cooldown of 1 reaches zero on the tick being sampled, so that tick may already fire.
    assign cd_ready[0] = (cooldown[0] <= 4'd1);
    assign cd_ready[1] = (cooldown[1] <= 4'd1);
    assign live_work   = work_of({key_state[8:5], key_state[3:0]}, fire_pend, cd_ready, rr);

    always_comb begin
        cur_player = 1'b0;
        cur_fire   = 1'b0;
        case (state)
            S0_FIRE: begin cur_player = seq_rr;  cur_fire = 1'b1; end
            S0_MOVE: cur_player = seq_rr;
            S1_FIRE: begin cur_player = ~seq_rr; cur_fire = 1'b1; end
            S1_MOVE: cur_player = ~seq_rr;
            default: ;
        endcase
        cur_dirs = dirs_of(snap_dirs, cur_player);
        if (state == IDLE)     cur_op = 3'd0;
        else if (cur_fire)     cur_op = 3'd4;
        else if (cur_dirs[0])  cur_op = 3'd0;
        else if (cur_dirs[1])  cur_op = 3'd1;
        else if (cur_dirs[2])  cur_op = 3'd2;
        else                   cur_op = 3'd3;
    end

    assign hs      = (state != IDLE) && bus.cmd_ready;
    assign fire_hs = (hs && cur_fire) ? (cur_player ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.tick) state_nx = pick(live_work, 0);
            S0_FIRE: if (hs) state_nx = pick(snap_work, 1);
            S0_MOVE: if (hs) state_nx = pick(snap_work, 2);
            S1_FIRE: if (hs) state_nx = pick(snap_work, 3);
            S1_MOVE: if (hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_state <= '0;
            fire_pend <= '0;
            cooldown  <= '0;
            rr        <= 1'b0;
            seq_rr    <= 1'b0;
            snap_dirs <= '0;
            snap_work <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (key_hit) key_state[key_idx] <= ~key_brk;
            for (int p = 0; p < 2; p++) begin
                // A fire make in the handshake cycle re-arms the request just cleared.
                if (fire_make[p])     fire_pend[p] <= 1'b1;
                else if (fire_hs[p])  fire_pend[p] <= 1'b0;
                if (fire_hs[p])                           cooldown[p] <= 4'(COOLDOWN);
                else if (bus.tick && cooldown[p] != 4'd0) cooldown[p] <= cooldown[p] - 4'd1;
            end
            if (state == IDLE && bus.tick) begin
                snap_dirs <= {key_state[8:5], key_state[3:0]};
                snap_work <= live_work;
                seq_rr    <= rr;
                rr        <= ~rr;
            end
            overrun_q <= bus.tick && (state != IDLE);
        end
    end

    assign bus.cmd_valid  = (state != IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.cmd_player = cur_player;
    assign bus.cmd_op     = cur_op;
    assign bus.overrun    = overrun_q;
    assign bus.key_state  = key_state;

endmodule

// File: tb/tb_tank_cmd_scheduler.sv
// Bench for tank_cmd_scheduler: directed vector table, hand sequences for cooldown,
// stall/overrun and reset, then random traffic against a command-list reference model.
module tb_tank_cmd_scheduler;
  localparam int CD = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tank_cmd_if bus();
  tank_cmd_scheduler #(.COOLDOWN(CD)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad = 0;

  // scoreboard: expected commands {player, op} still to be handshaked
  logic [3:0] exp_q[$];
  logic [9:0] m_ks;
  logic [1:0] m_fp;
  int         m_cd[2];
  logic       m_rr;
  logic       m_ovr;
  logic [7:0] key_tab[10] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h43, 8'h42, 8'h3B, 8'h4B, 8'h5A};

  typedef struct {
    logic       kv;
    logic [9:0] kc;
    logic       tk;
    logic       rdy;
    logic       ev;
    logic       ep;
    logic [2:0] eo;
    logic [9:0] eks;
  } vec_t;
  vec_t tab[22];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input logic kv, input logic [9:0] kc, input logic tk, input logic rdy);
    bus.key_valid = kv;
    bus.key_code  = kc;
    bus.tick      = tk;
    bus.cmd_ready = rdy;
  endtask

  task automatic cyc(input logic kv, input logic [9:0] kc, input logic tk, input logic rdy);
    drive(kv, kc, tk, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ks = '0;
    m_fp = '0;
    m_cd[0] = 0;
    m_cd[1] = 0;
    m_rr = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic do_reset();
    drive(1'b0, 10'h000, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_valid", bus.cmd_valid, 0);
    chk("rst_player", bus.cmd_player, 0);
    chk("rst_op", bus.cmd_op, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_key_state", bus.key_state, 0);
    rst = 1'b0;
    model_reset();
  endtask

  // Accepted tick: list this tick's commands, slot order rr then !rr, fire before move.
  task automatic build_seq();
    int p;
    int after;
    logic [3:0] dirs;
    logic found;
    for (int s = 0; s < 2; s++) begin
      p = (s == 0) ? int'(m_rr) : int'(!m_rr);
      after = (m_cd[p] > 0) ? m_cd[p] - 1 : 0;
      if (m_fp[p] && after == 0) exp_q.push_back({1'(p), 3'd4});
      dirs = m_ks[p*5 +: 4];
      found = 1'b0;
      for (int d = 0; d < 4; d++) begin
        if (dirs[d] && !found) begin
          exp_q.push_back({1'(p), 3'(d)});
          found = 1'b1;
        end
      end
    end
    m_rr = !m_rr;
  endtask

  task automatic model_edge(input logic kv, input logic [9:0] kc, input logic tk, input logic rdy);
    logic busy_pre;
    logic [3:0] c;
    logic [1:0] fired;
    int idx;
    busy_pre = (exp_q.size() != 0);
    fired = 2'b00;
    m_ovr = tk && busy_pre;
    if (tk && !busy_pre) build_seq();
    else if (busy_pre && rdy) begin
      c = exp_q.pop_front();
      if (c[2:0] == 3'd4) fired[c[3]] = 1'b1;
    end
    for (int p = 0; p < 2; p++) begin
      if (fired[p]) begin
        m_cd[p] = CD;
        m_fp[p] = 1'b0;
      end else if (tk && m_cd[p] > 0) begin
        m_cd[p] = m_cd[p] - 1;
      end
    end
    idx = -1;
    if (kv && !kc[9])
      for (int j = 0; j < 10; j++)
        if (key_tab[j] == kc[7:0]) idx = j;
    if (idx >= 0) begin
      m_ks[idx] = !kc[8];
      if (!kc[8] && (idx % 5) == 4) m_fp[idx / 5] = 1'b1;
    end
  endtask

  task automatic check_model();
    chk("m_valid", bus.cmd_valid, exp_q.size() != 0);
    chk("m_busy", bus.busy, exp_q.size() != 0);
    chk("m_overrun", bus.overrun, m_ovr);
    chk("m_key_state", bus.key_state, m_ks);
    if (exp_q.size() != 0) begin
      chk("m_player", bus.cmd_player, exp_q[0][3]);
      chk("m_op", bus.cmd_op, exp_q[0][2:0]);
    end
  endtask

  task automatic step_model(input logic kv, input logic [9:0] kc, input logic tk, input logic rdy);
    drive(kv, kc, tk, rdy);
    @(posedge clk);
    model_edge(kv, kc, tk, rdy);
    #1;
    check_model();
  endtask

  initial begin
    logic kv, tk, rdy;
    logic [9:0] kc;

    tab[0]  = '{1'b1, 10'h01D, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 10'h001};
    tab[1]  = '{1'b1, 10'h043, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 10'h021};
    tab[2]  = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 10'h021};
    tab[3]  = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 10'h021};
    tab[4]  = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 10'h021};
    tab[5]  = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 10'h021};
    tab[6]  = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 10'h021};
    tab[7]  = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 10'h021};
    tab[8]  = '{1'b1, 10'h143, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 10'h001};
    tab[9]  = '{1'b1, 10'h11D, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 10'h000};
    tab[10] = '{1'b1, 10'h01B, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 10'h002};
    tab[11] = '{1'b1, 10'h01C, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 10'h006};
    tab[12] = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 10'h006};
    tab[13] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 10'h006};
    tab[14] = '{1'b1, 10'h11B, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 10'h004};
    tab[15] = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 10'h004};
    tab[16] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 10'h004};
    tab[17] = '{1'b1, 10'h11C, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 10'h000};
    tab[18] = '{1'b1, 10'h21D, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 10'h000};
    tab[19] = '{1'b1, 10'h015, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 10'h000};
    tab[20] = '{1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 10'h000};
    tab[21] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 10'h000};

    drive(1'b0, 10'h000, 1'b0, 1'b0);
    #12;
    do_reset();

    // directed vector table: round robin, move priority, ignored codes
    for (int i = 0; i < 22; i++) begin
      cyc(tab[i].kv, tab[i].kc, tab[i].tk, tab[i].rdy);
      chk($sformatf("tab%0d_valid", i), bus.cmd_valid, tab[i].ev);
      chk($sformatf("tab%0d_busy", i), bus.busy, tab[i].ev);
      chk($sformatf("tab%0d_overrun", i), bus.overrun, 0);
      chk($sformatf("tab%0d_key_state", i), bus.key_state, tab[i].eks);
      if (tab[i].ev) begin
        chk($sformatf("tab%0d_player", i), bus.cmd_player, tab[i].ep);
        chk($sformatf("tab%0d_op", i), bus.cmd_op, tab[i].eo);
      end
    end

    // fire cooldown: COOLDOWN ticks between fires
    do_reset();
    cyc(1'b1, 10'h029, 1'b0, 1'b1);
    chk("cd_key_state", bus.key_state, 10'h010);
    cyc(1'b0, 10'h000, 1'b1, 1'b1);
    chk("cd_fire0_valid", bus.cmd_valid, 1);
    chk("cd_fire0_player", bus.cmd_player, 0);
    chk("cd_fire0_op", bus.cmd_op, 4);
    cyc(1'b0, 10'h000, 1'b0, 1'b1);
    chk("cd_fire0_done", bus.cmd_valid, 0);
    cyc(1'b1, 10'h029, 1'b0, 1'b1);
    for (int t = 1; t < CD; t++) begin
      cyc(1'b0, 10'h000, 1'b1, 1'b1);
      chk($sformatf("cd_tick%0d_valid", t), bus.cmd_valid, 0);
      cyc(1'b0, 10'h000, 1'b0, 1'b1);
    end
    cyc(1'b0, 10'h000, 1'b1, 1'b1);
    chk("cd_fire1_valid", bus.cmd_valid, 1);
    chk("cd_fire1_player", bus.cmd_player, 0);
    chk("cd_fire1_op", bus.cmd_op, 4);
    cyc(1'b0, 10'h000, 1'b0, 1'b1);
    chk("cd_fire1_done", bus.cmd_valid, 0);

    // stall with cmd_ready low, tick dropped with overrun pulse
    do_reset();
    cyc(1'b1, 10'h01D, 1'b0, 1'b0);
    cyc(1'b0, 10'h000, 1'b1, 1'b0);
    chk("stall_valid0", bus.cmd_valid, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 10'h000, i == 2, 1'b0);
      chk($sformatf("stall%0d_valid", i), bus.cmd_valid, 1);
      chk($sformatf("stall%0d_player", i), bus.cmd_player, 0);
      chk($sformatf("stall%0d_op", i), bus.cmd_op, 0);
      chk($sformatf("stall%0d_overrun", i), bus.overrun, i == 2);
    end
    cyc(1'b0, 10'h000, 1'b0, 1'b1);
    chk("stall_done_valid", bus.cmd_valid, 0);
    chk("stall_done_busy", bus.busy, 0);
    cyc(1'b0, 10'h000, 1'b0, 1'b1);
    chk("stall_no_extra", bus.cmd_valid, 0);

    // asynchronous reset while a command is pending
    do_reset();
    cyc(1'b1, 10'h01D, 1'b0, 1'b0);
    cyc(1'b0, 10'h000, 1'b1, 1'b0);
    chk("arst_pre_valid", bus.cmd_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", bus.cmd_valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_key_state", bus.key_state, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 10'h000, 1'b1, 1'b1);
    chk("arst_tick_valid", bus.cmd_valid, 0);
    cyc(1'b0, 10'h000, 1'b0, 1'b1);
    chk("arst_after_valid", bus.cmd_valid, 0);

    // random traffic against the reference model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      kv = ($urandom_range(0, 3) == 0);
      kc[9] = ($urandom_range(0, 15) == 0);
      kc[8] = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) < 9) kc[7:0] = key_tab[$urandom_range(0, 9)];
      else kc[7:0] = 8'($urandom_range(0, 255));
      tk = ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      step_model(kv, kc, tk, rdy);
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
